// File: rtl/red_lane_sequencer.sv
// red_lane_sequencer: sums LANES packed 7-bit lanes into a 9-bit result, one lane per cycle via an external adder
module red_lane_sequencer #(
  parameter int LANES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7*LANES-1:0] in_data,
  input  logic               flush,
  output logic [6:0]         add_a,
  output logic [6:0]         add_b,
  input  logic [6:0]         add_s,
  input  logic               add_cout,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8:0]         out_data
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  logic [1:0]         state_q, state_d;
  logic [8:0]         acc_q, acc_d;
  logic [1:0]         idx_q, idx_d;
  logic [7*LANES-1:0] op_q, op_d;
  logic [6:0]         lane_sel;
  always_comb begin
    lane_sel = '0;
    for (int k = 0; k < LANES; k++)
      if (idx_q == 2'(k)) lane_sel = op_q[7*k +: 7];
  end
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign out_data  = acc_q;
  assign add_a     = state_q == ACCUM ? acc_q[6:0] : 7'd0;
  assign add_b     = state_q == ACCUM ? lane_sel : 7'd0;
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    op_d    = op_q;
    if (flush) begin
      state_d = IDLE;
      idx_d   = '0;
    end else if (state_q == IDLE && in_valid) begin
      op_d    = in_data;
      acc_d   = {2'b00, in_data[6:0]};
      idx_d   = 2'd1;
      state_d = ACCUM;
    end else if (state_q == ACCUM) begin
      // upper bits only ever collect carries; 2 bits suffice for up to four lanes
      acc_d   = {acc_q[8:7] + {1'b0, add_cout}, add_s};
      idx_d   = idx_q + 2'd1;
      state_d = idx_q == 2'(LANES - 1) ? DONE : ACCUM;
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      idx_q   <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      op_q    <= op_d;
    end
  end
endmodule
